ifid_fetch_queue: RTL and testbench

//  Parametrised IF/ID boundary: a DEPTH-entry elastic queue followed by the ID-stage output register.
//  It decouples fetch from decode stalls, so fetch keeps issuing while decode is held.
//  It preserves the single-cycle IF->ID latency when the queue is empty.
//  It supports flush, NOP squashing of side-band bits, and PC+4 generation.

---
 rtl/ifid_fetch_queue.sv | 169 ++++++++++++++++
 tb/tb_ifid_fetch_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ifid_fetch_queue.sv
// rtl/ifid_fetch_queue.sv - IF/ID elastic fetch queue with ID-stage output register
//
// Purpose: DEPTH-entry FIFO between fetch and decode, followed by the ID register.
//          An empty queue is bypassed so IF->ID latency stays one cycle.
//          Flush drops everything; NOP entries have their side-band bits cleared.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    discard queue contents and bubble the ID register
//   if_valid/if_ready        fetch handshake
//   if_pc/if_instr           fetched PC and instruction
//   if_ecall/if_pred_taken   fetch side-band bits
//   id_stall                 decode holds the ID register
//   id_valid/id_pc/id_pc_plus4/id_instr/id_ecall/id_pred_taken  ID register outputs
//   q_count                  queue occupancy, excluding the ID register
module ifid_fetch_queue #(
    parameter int              DEPTH     = 4,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [XLEN-1:0]            if_pc,
    input  logic [XLEN-1:0]            if_instr,
    input  logic                       if_ecall,
    input  logic                       if_pred_taken,
    input  logic                       id_stall,
    output logic                       id_valid,
    output logic [XLEN-1:0]            id_pc,
    output logic [XLEN-1:0]            id_pc_plus4,
    output logic [XLEN-1:0]            id_instr,
    output logic                       id_ecall,
    output logic                       id_pred_taken,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [XLEN-1:0] mem_instr_q [DEPTH];
    logic            mem_ecall_q [DEPTH];
    logic            mem_pred_q  [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic            id_ecall_q, id_ecall_d;
    logic            id_pred_q, id_pred_d;

    logic            push;
    logic            enq;
    logic            in_ecall;
    logic            in_pred;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    // No pass-through at full: a same-cycle pop does not open a slot.
    assign if_ready = (count_q < CW'(DEPTH)) & ~flush;
    assign push     = if_valid & if_ready;

    // A bubble fetched as NOP must not carry stale side-band bits.
    assign in_ecall = if_ecall      & (if_instr != NOP_INSTR);
    assign in_pred  = if_pred_taken & (if_instr != NOP_INSTR);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        id_valid_d    = id_valid_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_instr_d    = id_instr_q;
        id_ecall_d    = id_ecall_q;
        id_pred_d     = id_pred_q;
        enq           = 1'b0;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            id_ecall_d = 1'b0;
            id_pred_d  = 1'b0;
        end else if (id_stall) begin
            enq = push;
            if (push) count_d = count_q + CW'(1);
        end else if (count_q != '0) begin
            id_valid_d    = 1'b1;
            id_pc_d       = mem_pc_q[rd_ptr_q];
            id_pc_plus4_d = mem_pc_q[rd_ptr_q] + XLEN'(4);
            id_instr_d    = mem_instr_q[rd_ptr_q];
            id_ecall_d    = mem_ecall_q[rd_ptr_q];
            id_pred_d     = mem_pred_q[rd_ptr_q];
            rd_ptr_d      = ptr_inc(rd_ptr_q);
            enq           = push;
            if (!push) count_d = count_q - CW'(1);
        end else if (push) begin
            // Empty queue: bypass straight into ID for single-cycle latency.
            id_valid_d    = 1'b1;
            id_pc_d       = if_pc;
            id_pc_plus4_d = if_pc + XLEN'(4);
            id_instr_d    = if_instr;
            id_ecall_d    = in_ecall;
            id_pred_d     = in_pred;
        end else begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            id_ecall_d = 1'b0;
            id_pred_d  = 1'b0;
        end

        if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            id_valid_q    <= 1'b0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= XLEN'(4);
            id_instr_q    <= NOP_INSTR;
            id_ecall_q    <= 1'b0;
            id_pred_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_instr_q    <= id_instr_d;
            id_ecall_q    <= id_ecall_d;
            id_pred_q     <= id_pred_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_pc_q[wr_ptr_q]    <= if_pc;
            mem_instr_q[wr_ptr_q] <= if_instr;
            mem_ecall_q[wr_ptr_q] <= in_ecall;
            mem_pred_q[wr_ptr_q]  <= in_pred;
        end
    end

    assign id_valid      = id_valid_q;
    assign id_pc         = id_pc_q;
    assign id_pc_plus4   = id_pc_plus4_q;
    assign id_instr      = id_instr_q;
    assign id_ecall      = id_ecall_q;
    assign id_pred_taken = id_pred_q;
    assign q_count       = count_q;

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// tb/tb_ifid_fetch_queue.sv - directed self-checking bench for ifid_fetch_queue
module tb_ifid_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ecall;
    logic        if_pred_taken;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        id_ecall;
    logic        id_pred_taken;
    logic [2:0]  q_count;

    int total = 0;
    int bad   = 0;

    ifid_fetch_queue #(.DEPTH(4), .XLEN(32), .NOP_INSTR(32'h00000013)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .if_ecall(if_ecall), .if_pred_taken(if_pred_taken), .id_stall(id_stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
        .id_ecall(id_ecall), .id_pred_taken(id_pred_taken), .q_count(q_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic e, input logic p);
        if_valid = v; if_pc = pc; if_instr = ins; if_ecall = e; if_pred_taken = p;
    endtask

    task automatic test_reset();
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL reset_qcount got=%0d exp=0", q_count); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        total++; if (id_instr !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=00000013", id_instr); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
        total++; if (id_pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h exp=4", id_pc_plus4); end
        total++; if ({id_ecall, id_pred_taken} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", id_ecall, id_pred_taken); end
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
            total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL byp_ready[%0d] got=%b exp=1", i, if_ready); end
            step();
            total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL byp_valid[%0d] got=%b exp=1", i, id_valid); end
            total++; if (id_pc !== 32'h100 + 32'(4*i)) begin bad++; $display("FAIL byp_pc[%0d] got=%h exp=%h", i, id_pc, 32'h100 + 32'(4*i)); end
            total++; if (id_pc_plus4 !== 32'h104 + 32'(4*i)) begin bad++; $display("FAIL byp_pc4[%0d] got=%h exp=%h", i, id_pc_plus4, 32'h104 + 32'(4*i)); end
            total++; if (id_instr !== 32'hA000_0000 + 32'(i)) begin bad++; $display("FAIL byp_instr[%0d] got=%h exp=%h", i, id_instr, 32'hA000_0000 + 32'(i)); end
            total++; if (q_count !== 3'd0) begin bad++; $display("FAIL byp_qcount[%0d] got=%0d exp=0", i, q_count); end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL byp_bubble_valid got=%b exp=0", id_valid); end
        total++; if (id_instr !== 32'h13) begin bad++; $display("FAIL byp_bubble_instr got=%h exp=00000013", id_instr); end
        total++; if (id_pc !== 32'h108) begin bad++; $display("FAIL byp_bubble_pc got=%h exp=00000108", id_pc); end
    endtask

    task automatic test_stall_fill_drain();
        id_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h200 + 32'(4*i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
            total++; if (if_ready !== (i < 4)) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=%b", i, if_ready, (i < 4)); end
            step();
            total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d] got=%b exp=0", i, id_valid); end
        end
        total++; if (q_count !== 3'd4) begin bad++; $display("FAIL stall_full got=%0d exp=4", q_count); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        id_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (id_pc !== 32'h200 + 32'(4*k)) begin bad++; $display("FAIL drain_pc[%0d] got=%h exp=%h", k, id_pc, 32'h200 + 32'(4*k)); end
            total++; if (id_instr !== 32'hB000_0000 + 32'(k)) begin bad++; $display("FAIL drain_instr[%0d] got=%h exp=%h", k, id_instr, 32'hB000_0000 + 32'(k)); end
            total++; if (q_count !== 3'(3 - k)) begin bad++; $display("FAIL drain_qcount[%0d] got=%0d exp=%0d", k, q_count, 3 - k); end
        end
        step();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", id_valid); end
    endtask

    task automatic test_flush();
        id_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h300 + 32'(4*i), 32'hC000_0000 + 32'(i), 1'b1, 1'b1);
            step();
        end
        total++; if (q_count !== 3'd2) begin bad++; $display("FAIL flush_pre got=%0d exp=2", q_count); end
        drive(1'b1, 32'h308, 32'hC000_0002, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", if_ready); end
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL flush_qcount got=%0d exp=0", q_count); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", id_valid); end
        total++; if (id_instr !== 32'h13) begin bad++; $display("FAIL flush_instr got=%h exp=00000013", id_instr); end
        total++; if (id_pc !== 32'h20C) begin bad++; $display("FAIL flush_pc_hold got=%h exp=0000020c", id_pc); end
        id_stall = 1'b0;
        step();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL flush_lost got=%b exp=0", id_valid); end
    endtask

    task automatic test_nop_squash();
        drive(1'b1, 32'h400, 32'h00000013, 1'b1, 1'b1);
        step();
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL nop_valid got=%b exp=1", id_valid); end
        total++; if ({id_ecall, id_pred_taken} !== 2'b00) begin bad++; $display("FAIL nop_flags got=%b%b exp=00", id_ecall, id_pred_taken); end
        drive(1'b1, 32'h404, 32'h00000073, 1'b1, 1'b1);
        step();
        total++; if ({id_ecall, id_pred_taken} !== 2'b11) begin bad++; $display("FAIL ecall_flags got=%b%b exp=11", id_ecall, id_pred_taken); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        id_stall = 1'b1;
        drive(1'b1, 32'h500, 32'hD000_0000, 1'b0, 1'b0); step();
        drive(1'b1, 32'h504, 32'hD000_0001, 1'b0, 1'b0); step();
        id_stall = 1'b0;
        drive(1'b1, 32'hFFFF_FFFC, 32'hD000_0002, 1'b0, 1'b1); step();
        total++; if (id_pc !== 32'h500) begin bad++; $display("FAIL b2b_pc0 got=%h exp=00000500", id_pc); end
        total++; if (q_count !== 3'd2) begin bad++; $display("FAIL b2b_q0 got=%0d exp=2", q_count); end
        drive(1'b1, 32'h508, 32'hD000_0003, 1'b0, 1'b0); step();
        total++; if (id_pc !== 32'h504) begin bad++; $display("FAIL b2b_pc1 got=%h exp=00000504", id_pc); end
        total++; if (q_count !== 3'd2) begin bad++; $display("FAIL b2b_q1 got=%0d exp=2", q_count); end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); step();
        total++; if (id_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL b2b_pc2 got=%h exp=fffffffc", id_pc); end
        total++; if (id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL b2b_wrap got=%h exp=00000000", id_pc_plus4); end
        total++; if (id_pred_taken !== 1'b1) begin bad++; $display("FAIL b2b_pred got=%b exp=1", id_pred_taken); end
        total++; if (q_count !== 3'd1) begin bad++; $display("FAIL b2b_q2 got=%0d exp=1", q_count); end
        step();
        total++; if (id_pc !== 32'h508) begin bad++; $display("FAIL b2b_pc3 got=%h exp=00000508", id_pc); end
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL b2b_q3 got=%0d exp=0", q_count); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h600, 32'hE000_0000, 1'b0, 1'b0); step();
        id_stall = 1'b1;
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 32'h600 + 32'(4*i), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if (q_count !== 3'd3) begin bad++; $display("FAIL ar_pre_q got=%0d exp=3", q_count); end
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b exp=1", id_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (q_count !== 3'd0) begin bad++; $display("FAIL ar_qcount got=%0d exp=0", q_count); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", id_valid); end
        total++; if (id_instr !== 32'h13) begin bad++; $display("FAIL ar_instr got=%h exp=00000013", id_instr); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL ar_pc got=%h exp=0", id_pc); end
        total++; if (id_pc_plus4 !== 32'h4) begin bad++; $display("FAIL ar_pc4 got=%h exp=4", id_pc_plus4); end
        id_stall = 1'b0;
        step();
        rst = 1'b0;
        step();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL ar_after got=%b exp=0", id_valid); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; id_stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); step();
        test_reset();
        rst = 1'b0;
        step();
        test_bypass();
        test_stall_fill_drain();
        test_flush();
        test_nop_squash();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
